// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot/fetch controller.
//   imem_state_e     : controller states
//   IMEM_DEPTH_BYTES : default instruction memory size in bytes
//   IMEM_END_MARKER  : default end-of-program word / halt instruction
package imem_pkg;

  typedef enum logic [2:0] {
    LOAD,
    WRITE,
    FILL,
    RUN,
    HALT
  } imem_state_e;

  localparam int unsigned IMEM_DEPTH_BYTES = 128;
  localparam logic [31:0] IMEM_END_MARKER  = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one 32-bit program word and presents it as four little-endian byte beats.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture word_i and restart at byte 0
//   step_i       : advance to the next byte beat (wraps after byte 3)
//   word_i       : word to capture
//   byte_o       : current byte, word_q[8*idx+:8]
//   idx_o        : current byte index 0..3
//   last_o       : current beat is byte 3
module imem_byte_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic [1:0]  idx_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = 2'd0;
    end else if (step_i) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_o = word_q[{idx_q, 3'b000} +: 8];
  assign idx_o  = idx_q;
  assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot and fetch controller for a byte-wide instruction memory.
// Loads 32-bit program words from a valid/ready stream as four little-endian byte
// writes, pads the remainder with 0xFF after the end marker, then hands the read
// address to the core and halts it on the end marker or an out-of-range PC.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   load_valid/load_data/ready  : program word stream
//   mem_we/mem_waddr/mem_wdata  : byte write port of the memory array
//   core_pc, mem_raddr          : core fetch address, array read address
//   fetch_instr                 : word returned by the array at mem_raddr
//   core_run                    : core may commit this cycle
//   last_instr_flag, fetch_err, load_full : sticky status flags
//   reload                      : restart loading from HALT
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = IMEM_DEPTH_BYTES,
  parameter logic [31:0] END_MARKER  = IMEM_END_MARKER,
  parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  input  logic [31:0]   core_pc,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   fetch_instr,
  output logic          core_run,
  output logic          last_instr_flag,
  output logic          fetch_err,
  output logic          load_full,
  input  logic          reload
);

  // wptr is one bit wider than the byte address so it can reach DEPTH_BYTES.
  localparam logic [AW:0] WPTR_FULL = (AW+1)'(DEPTH_BYTES);
  localparam logic [AW:0] WPTR_LAST = (AW+1)'(DEPTH_BYTES - 1);

  imem_state_e   state_q, state_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          full_q, full_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;

  logic          ser_load, ser_step, ser_last;
  logic [7:0]    ser_byte;
  logic [1:0]    ser_idx;

  logic          in_range, is_marker;

  imem_byte_serializer u_ser (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (ser_load),
    .step_i (ser_step),
    .word_i (load_data),
    .byte_o (ser_byte),
    .idx_o  (ser_idx),
    .last_o (ser_last)
  );

  assign in_range  = (core_pc <= 32'(DEPTH_BYTES - 4)) && (core_pc[1:0] == 2'b00);
  assign is_marker = (fetch_instr == END_MARKER);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    last_d     = last_q;
    err_d      = err_q;
    full_d     = full_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    core_run   = 1'b0;
    ser_load   = 1'b0;
    ser_step   = 1'b0;
    mem_raddr  = wptr_q[AW-1:0];

    unique case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (load_data == END_MARKER) begin
            state_d = (wptr_q == WPTR_FULL) ? RUN : FILL;
          end else begin
            ser_load = 1'b1;
            state_d  = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we   = 1'b1;
        waddr_d  = wptr_q[AW-1:0] + AW'(ser_idx);
        wdata_d  = ser_byte;
        ser_step = 1'b1;
        if (ser_last) begin
          wptr_d = wptr_q + (AW+1)'(4);
          if (wptr_d == WPTR_FULL) begin
            full_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      FILL: begin
        mem_we  = 1'b1;
        waddr_d = wptr_q[AW-1:0];
        wdata_d = 8'hFF;
        wptr_d  = wptr_q + (AW+1)'(1);
        if (wptr_q == WPTR_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_raddr = core_pc[AW-1:0];
        core_run  = !is_marker && in_range;
        if (is_marker) begin
          last_d = 1'b1;
        end
        if (!in_range) begin
          err_d = 1'b1;
        end
        if (is_marker || !in_range) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (reload) begin
          state_d = LOAD;
          wptr_d  = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // The write address/data are driven from the registers' next value so they
  // follow the live beat while writing and hold the last beat otherwise.
  assign mem_waddr = waddr_d;
  assign mem_wdata = wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      full_q  <= full_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign last_instr_flag = last_q;
  assign fetch_err       = err_q;
  assign load_full       = full_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: stimulus tasks push the expected byte
// writes into a queue and a monitor pops/compares whenever mem_we is seen.
module tb_imem_boot_ctrl;

  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] MARK  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_ready;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [31:0] core_pc = 32'd0;
  logic [6:0]  mem_raddr;
  logic [31:0] fetch_instr;
  logic        core_run;
  logic        last_instr_flag;
  logic        fetch_err;
  logic        load_full;
  logic        reload = 1'b0;

  logic [7:0] arr [DEPTH];      // the memory array the block writes into
  logic [7:0] ref_mem [DEPTH];  // reference contents
  int         ref_wptr;
  bit         exp_last, exp_err, exp_full;
  wr_t        exp_q[$];
  int         total = 0;
  int         bad = 0;

  imem_boot_ctrl #(
    .DEPTH_BYTES (DEPTH),
    .END_MARKER  (MARK),
    .AW          (7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .core_pc         (core_pc),
    .mem_raddr       (mem_raddr),
    .fetch_instr     (fetch_instr),
    .core_run        (core_run),
    .last_instr_flag (last_instr_flag),
    .fetch_err       (fetch_err),
    .load_full       (load_full),
    .reload          (reload)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) arr[mem_waddr] <= mem_wdata;
  end

  assign fetch_instr = {arr[mem_raddr + 7'd3], arr[mem_raddr + 7'd2],
                        arr[mem_raddr + 7'd1], arr[mem_raddr]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every byte write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h required no write",
                 mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {25'd0, mem_waddr}, {25'd0, e.a});
        chk("write_data", {24'd0, mem_wdata}, {24'd0, e.d});
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [6:0] a;
    a = pc[6:0];
    return {ref_mem[a + 7'd3], ref_mem[a + 7'd2], ref_mem[a + 7'd1], ref_mem[a]};
  endfunction

  function automatic void clear_model();
    ref_wptr = 0;
    exp_last = 1'b0;
    exp_err  = 1'b0;
    exp_full = 1'b0;
  endfunction

  // Handshake only: all tasks start and end 1 time unit after a rising edge.
  task automatic offer(input logic [31:0] w);
    int n = 0;
    load_valid = 1'b1;
    load_data  = w;
    forever begin
      @(negedge clk);
      if (load_ready) break;
      n++;
      if (n > 20) break;
    end
    if (!load_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got load_ready=0 for 20 cycles required 1");
      load_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = $urandom;
  endtask

  task automatic send_word(input logic [31:0] w);
    if (w == MARK) begin
      for (int a = ref_wptr; a < DEPTH; a++) begin
        exp_q.push_back('{a: 7'(a), d: 8'hFF});
        ref_mem[a] = 8'hFF;
      end
      ref_wptr = DEPTH;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{a: 7'(ref_wptr + i), d: w[8*i +: 8]});
        ref_mem[ref_wptr + i] = w[8*i +: 8];
      end
      ref_wptr += 4;
      if (ref_wptr == DEPTH) exp_full = 1'b1;
    end
    offer(w);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d writes pending required 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic run_step(input logic [31:0] pc, output bit halted);
    bit          inr;
    logic [31:0] w;
    core_pc = pc;
    inr = (pc <= DEPTH - 4) && (pc[1:0] == 2'b00);
    w = ref_word(pc);
    @(negedge clk);
    chk("raddr_run", {25'd0, mem_raddr}, {25'd0, pc[6:0]});
    chk("core_run", {31'd0, core_run}, {31'd0, (inr && w != MARK)});
    halted = !(inr && w != MARK);
    if (w == MARK) exp_last = 1'b1;
    if (!inr) exp_err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_halt();
    @(negedge clk);
    chk("halt_core_run", {31'd0, core_run}, 32'd0);
    chk("halt_mem_we", {31'd0, mem_we}, 32'd0);
    chk("halt_flags", {29'd0, last_instr_flag, fetch_err, load_full},
        {29'd0, exp_last, exp_err, exp_full});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    clear_model();
    @(negedge clk);
    chk("reload_ready", {31'd0, load_ready}, 32'd1);
    chk("reload_flags", {29'd0, last_instr_flag, fetch_err, load_full}, 32'd0);
    chk("reload_raddr", {25'd0, mem_raddr}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_full_array();
    logic [31:0] w;
    for (int k = 0; k < DEPTH / 4; k++) begin
      w = $urandom;
      if (w == MARK) w = 32'h0000_0013;
      send_word(w);
    end
    drain();
  endtask

  initial begin
    bit          h;
    int          cnt;
    int          n;
    logic [31:0] w;
    logic [31:0] pc;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    clear_model();

    // Reset values
    @(negedge clk);
    chk("reset_ready", {31'd0, load_ready}, 32'd1);
    chk("reset_outputs", {mem_we, core_run, mem_waddr, mem_wdata, mem_raddr}, 32'd0);
    chk("reset_flags", {29'd0, last_instr_flag, fetch_err, load_full}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed program, with write-to-ready latency on the first word
    send_word(32'h0050_0093);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (load_ready || cnt > 10) break;
      cnt++;
    end
    chk("ready_latency", cnt, 32'd4);
    @(posedge clk);
    #1;
    send_word(32'h0010_0113);
    send_word(32'h0020_81B3);
    send_word(MARK);
    drain();
    chk("no_full_with_marker", {31'd0, load_full}, 32'd0);
    run_step(32'd0, h);

    // reload is ignored while running
    core_pc = 32'd0;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_in_run", {31'd0, core_run}, 32'd1);
    @(posedge clk);
    #1;
    run_step(32'd12, h);
    check_halt();

    // Full array without a marker, then a 33rd word must be refused
    do_reload();
    load_full_array();
    chk("load_full_set", {31'd0, load_full}, 32'd1);
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    run_step(32'd0, h);
    @(negedge clk);
    chk("ready_when_full", {31'd0, load_ready}, 32'd0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    run_step(32'd126, h);
    check_halt();

    do_reload();
    load_full_array();
    run_step(32'd4, h);
    run_step(32'd6, h);
    check_halt();

    // Reset during the second write beat of the third word
    do_reload();
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    w = 32'hA5C3_1E77;
    exp_q.push_back('{a: 7'(ref_wptr), d: w[7:0]});
    ref_mem[ref_wptr] = w[7:0];
    offer(w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    chk("abort_ready", {31'd0, load_ready}, 32'd1);
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_wptr", {25'd0, mem_raddr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(32'h0000_0513);
    send_word(MARK);
    drain();
    run_step(32'd0, h);
    run_step(32'd4, h);
    check_halt();

    // Randomised programs and fetch sequences
    for (int it = 0; it < 8; it++) begin
      do_reload();
      n = $urandom_range(0, 32);
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        if (w == MARK) w = 32'd0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_word(w);
      end
      if (n < 32) send_word(MARK);
      drain();
      chk("rand_full", {31'd0, load_full}, {31'd0, exp_full});
      h = 1'b0;
      for (int s = 0; s < 12 && !h; s++) begin
        if (s == 11) pc = DEPTH + $urandom_range(0, 3);
        else if ($urandom_range(0, 7) == 0) pc = $urandom_range(0, 140);
        else pc = {$urandom_range(0, 31), 2'b00};
        run_step(pc, h);
      end
      check_halt();
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and fetch controller for the byte-wide instruction memory of the single-cycle RISC-V core. Out of reset it takes 32-bit program words over a valid/ready stream and writes each one into the 8-bit memory array as four little-endian byte writes. When it sees the end marker it pads the rest of the array with 0xFF, then hands the memory read address to the core. It stops the core when a fetched instruction equals the end marker or the PC leaves the array.

## Interface
Parameters:
- DEPTH_BYTES, 128: instruction memory size in bytes. Must be a multiple of 4 and a power of 2.
- END_MARKER, 32'hFFFF_FFFF: end-of-program word and halt instruction.
- AW, $clog2(DEPTH_BYTES): width of the byte address.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous reset, active-high.
- load_valid  in  1: a program word is offered.
- load_data  in  32: program word, little-endian in memory.
- load_ready  out  1: the controller accepts a word this cycle.
- mem_we  out  1: byte write strobe to the memory array.
- mem_waddr  out  AW: byte write address.
- mem_wdata  out  8: byte write data.
- core_pc  in  32: core fetch address.
- mem_raddr  out  AW: read address to the array; the array returns 4 bytes starting here.
- fetch_instr  in  32: word returned by the array combinationally, {RF[a+3],RF[a+2],RF[a+1],RF[a]}.
- core_run  out  1: the core may commit this cycle.
- last_instr_flag  out  1: sticky; set when halted on END_MARKER.
- fetch_err  out  1: sticky; set when halted on an out-of-range PC.
- load_full  out  1: sticky; set when the array filled before a marker arrived.
- reload  in  1: single-cycle pulse; restarts loading from HALT.

## Operation
States: LOAD, WRITE, FILL, RUN, HALT. Reset enters LOAD with wptr=0, byte_idx=0 and all flags cleared.

- **LOAD**
  - load_ready=1.
  - On load_valid with load_data==END_MARKER: the word is accepted and not written. Go to FILL, or to RUN if wptr==DEPTH_BYTES.
  - On any other valid word: latch it into word_q and go to WRITE.
- **WRITE**
  - Four cycles, byte_idx 0..3.
  - Each cycle: mem_we=1, mem_waddr=wptr+byte_idx, mem_wdata=word_q[8*byte_idx+:8].
  - After byte 3: wptr+=4.
  - If the new wptr==DEPTH_BYTES, set load_full and go to RUN. Otherwise go to LOAD.
- **FILL**
  - One byte per cycle: mem_we=1, mem_waddr=wptr, mem_wdata=8'hFF, wptr+=1.
  - After writing address DEPTH_BYTES-1, go to RUN.
- **RUN**
  - mem_raddr=core_pc[AW-1:0].
  - core_run = (fetch_instr!=END_MARKER) && in_range, where in_range = core_pc<=DEPTH_BYTES-4 and core_pc[1:0]==0.
  - fetch_instr==END_MARKER: go to HALT and set last_instr_flag.
  - !in_range: go to HALT and set fetch_err.
  - If both conditions hold in the same cycle, set both flags.
- **HALT**
  - core_run=0 and mem_we=0.
  - reload: go to LOAD, wptr=0, clear all three flags.
  - reload is ignored in every other state.
- Outside WRITE and FILL, mem_we=0. mem_waddr and mem_wdata hold their last values; they are don't-care when mem_we=0.
- Outside RUN, mem_raddr=wptr. The array is not read by the core in these states.
- load_ready=0 in every state except LOAD. A word offered in any other state is not consumed.

## Timing
- Reset values: load_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, core_run=0, all flags 0.
- All state, wptr, word_q and flags are registered.
- load_ready, mem_we and core_run are decoded combinationally from state and inputs.
- Word accepted at edge N: bytes are written at edges N+1 through N+4, and load_ready is high again in cycle N+5. Throughput is 1 word per 5 cycles.
- Marker accepted at edge N with wptr=W: FILL covers edges N+1 through N+DEPTH_BYTES-W. RUN is the following cycle.
- The halt condition is seen combinationally. core_run drops in the same cycle and HALT is entered at the next edge.
- Asserting rst at any point, including mid-WRITE or mid-FILL, aborts immediately to LOAD. Partially written bytes stay in the array.

## Structure
- Shared package imem_pkg holds:
  - the state enum imem_state_e {LOAD, WRITE, FILL, RUN, HALT};
  - the END_MARKER default;
  - the DEPTH_BYTES default.
- The instruction memory array itself is not part of this block.
- One natural sub-module: imem_byte_serializer (word_q plus byte_idx counter, emitting 4 byte beats). The top FSM instantiates it.

## Test plan
- Reset, then stream 0x00500093, 0x00100113, 0x002081B3, END_MARKER with load_valid held high. Expect:
  - byte writes 93,00,50,00 at addresses 0..3, then the next word's bytes at 4..7 and 8..11;
  - 116 writes of FF covering addresses 12..127;
  - RUN entered; core_pc=0 gives mem_raddr=0 and core_run=1.
- In RUN, drive core_pc=12 (an FF-padded word). Expect core_run=0 in that cycle, then HALT and last_instr_flag=1 at the next edge.
- Load 32 non-marker words. Expect load_full=1 and RUN entered without a marker or any FILL. A 33rd word offered afterwards sees load_ready=0.
- In RUN, drive core_pc=126, then core_pc=6. Expect HALT with fetch_err=1 and last_instr_flag=0.
- Assert rst at the second WRITE beat. Expect LOAD in the following cycle with load_ready=1, mem_we=0 and wptr=0. A new stream then writes starting at address 0.
- From HALT, pulse reload. Expect LOAD with all flags cleared. A reload pulsed during RUN has no effect.
